armleo_regfile_reader: RTL and testbench

ARMLEO_REGFILE_READER -- requirements
Module: armleo_regfile_reader

---
 rtl/armleo_regfile_reader_if.sv | 24 ++
 rtl/armleo_regfile_reader.sv | 129 ++++++++++++
 tb/tb_armleo_regfile_reader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/armleo_regfile_reader_if.sv
// Operand-read request/response bundle between the requester and armleo_regfile_reader.
interface armleo_regfile_reader_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DEPTH_LOG2-1:0] req_rs1_addr;
  logic [DEPTH_LOG2-1:0] req_rs2_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_rs1_data;
  logic [WIDTH-1:0]      rsp_rs2_data;

  modport master (
    output req_valid, req_rs1_addr, req_rs2_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data
  );

  modport slave (
    input  req_valid, req_rs1_addr, req_rs2_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data
  );
endinterface

// File: rtl/armleo_regfile_reader.sv
// Two-operand register file reader with a one-entry response stage and x0 masking.
// Define ARMLEO_REGFILE_READER_BYPASS_EN to forward/snoop regfile writes into pending operands.
module armleo_regfile_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  armleo_regfile_reader_if.slave bus,
  output logic                  rs1_read,
  output logic                  rs2_read,
  output logic [DEPTH_LOG2-1:0] rs1_addr,
  output logic [DEPTH_LOG2-1:0] rs2_addr,
  input  logic [WIDTH-1:0]      rs1_rdata,
  input  logic [WIDTH-1:0]      rs2_rdata,
  input  logic                  wr_write,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_wdata
);

  typedef enum logic [1:0] {IDLE, DATA, HOLD} state_t;

  state_t state_reg;
  logic   rsp_valid_int;
  logic   accept;

  logic [1:0][DEPTH_LOG2-1:0] req_addr;
  logic [1:0][WIDTH-1:0]      rdata;
  logic [1:0][WIDTH-1:0]      rsp_data;

  // Reset gates the response so no handshake can complete in a reset cycle.
  assign rsp_valid_int = !rst && (state_reg != IDLE);
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.req_ready = !rst && (!rsp_valid_int || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  assign rs1_read = accept;
  assign rs2_read = accept;
  assign rs1_addr = bus.req_rs1_addr;
  assign rs2_addr = bus.req_rs2_addr;

  assign req_addr[0] = bus.req_rs1_addr;
  assign req_addr[1] = bus.req_rs2_addr;
  assign rdata[0]    = rs1_rdata;
  assign rdata[1]    = rs2_rdata;

  assign bus.rsp_rs1_data = rsp_data[0];
  assign bus.rsp_rs2_data = rsp_data[1];

`ifndef ARMLEO_REGFILE_READER_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_write, wr_addr, wr_wdata};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      logic [DEPTH_LOG2-1:0] addr_reg;
      logic [WIDTH-1:0]      hold_reg;
      logic [WIDTH-1:0]      data_cur;

`ifdef ARMLEO_REGFILE_READER_BYPASS_EN
      logic             byp_valid_reg;
      logic [WIDTH-1:0] byp_data_reg;
      logic             req_hit;
      logic             snoop_hit;

      // req_hit forwards a write racing the read; snoop_hit tracks writes after accept.
      assign req_hit   = wr_write && (wr_addr != '0) && (wr_addr == req_addr[gi]);
      assign snoop_hit = wr_write && (wr_addr != '0) && (wr_addr == addr_reg);
      assign data_cur  = (addr_reg == '0) ? '0 :
                         (byp_valid_reg ? byp_data_reg : rdata[gi]);

      always_ff @(posedge clk) begin
        if (rst) begin
          addr_reg      <= '0;
          hold_reg      <= '0;
          byp_valid_reg <= 1'b0;
          byp_data_reg  <= '0;
        end else begin
          if (accept) begin
            addr_reg      <= req_addr[gi];
            byp_valid_reg <= req_hit;
            byp_data_reg  <= wr_wdata;
          end
          if (state_reg == DATA && !bus.rsp_ready)
            hold_reg <= snoop_hit ? wr_wdata : data_cur;
          else if (state_reg == HOLD && snoop_hit)
            hold_reg <= wr_wdata;
        end
      end
`else
      assign data_cur = (addr_reg == '0) ? '0 : rdata[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          addr_reg <= '0;
          hold_reg <= '0;
        end else begin
          if (accept)
            addr_reg <= req_addr[gi];
          if (state_reg == DATA && !bus.rsp_ready)
            hold_reg <= data_cur;
        end
      end
`endif

      assign rsp_data[gi] = rst                 ? '0       :
                            (state_reg == DATA) ? data_cur :
                            (state_reg == HOLD) ? hold_reg : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else if (accept) begin
      state_reg <= DATA;
    end else begin
      case (state_reg)
        IDLE:    state_reg <= IDLE;
        DATA:    state_reg <= bus.rsp_ready ? IDLE : HOLD;
        HOLD:    state_reg <= bus.rsp_ready ? IDLE : HOLD;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_armleo_regfile_reader.sv
// Self-checking bench for armleo_regfile_reader: directed scenarios plus randomized traffic
// against an architectural model (operand = current register value, or accept-time snapshot).
module tb_armleo_regfile_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rs1_read, rs2_read;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_rdata, rs2_rdata;
  logic        wr_write = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_wdata = '0;
  logic [31:0] mem [32];

  int n_checks = 0;
  int n_pass   = 0;

`ifdef ARMLEO_REGFILE_READER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  armleo_regfile_reader_if #(.WIDTH(32), .DEPTH_LOG2(5)) bus ();

  armleo_regfile_reader #(.WIDTH(32), .DEPTH_LOG2(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rs1_read  (rs1_read),
    .rs2_read  (rs2_read),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_rdata (rs1_rdata),
    .rs2_rdata (rs2_rdata),
    .wr_write  (wr_write),
    .wr_addr   (wr_addr),
    .wr_wdata  (wr_wdata)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 0) return 32'hDEAD_BEEF;  // garbage in x0 so masking is observable
    if (i == 3) return 32'h0000_1234;
    return 32'h1000_0000 + i * 32'h101;
  endfunction

  // Regfile: read data one cycle after enable, read-before-write, x0 never written.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (wr_write && wr_addr != 5'd0) begin
      mem[wr_addr] <= wr_wdata;
    end
    if (rs1_read) rs1_rdata <= mem[rs1_addr];
    if (rs2_read) rs2_rdata <= mem[rs2_addr];
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_rs1_addr = '0;
    bus.req_rs2_addr = '0;
    bus.rsp_ready    = 1'b0;
  end

  task automatic step(input logic r, input logic v, input logic [4:0] a1, input logic [4:0] a2,
                      input logic rr, input logic w, input logic [4:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst              = r;
    bus.req_valid    = v;
    bus.req_rs1_addr = a1;
    bus.req_rs2_addr = a2;
    bus.rsp_ready    = rr;
    wr_write         = w;
    wr_addr          = wa;
    wr_wdata         = wd;
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 1, 5'd3, 5'd4, 1, 0, 0, 0);
    step(1, 1, 5'd3, 5'd4, 1, 0, 0, 0);
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if ({rs1_read, rs2_read} !== 2'b00) $display("FAIL reset_read_en: got %b want 00", {rs1_read, rs2_read}); else n_pass++;
    n_checks++; if (bus.rsp_rs1_data !== 32'h0) $display("FAIL reset_rs1_data: got %h want 0", bus.rsp_rs1_data); else n_pass++;
    $display("reset done");
  endtask

  task automatic test_basic();
    step(0, 1, 5'd3, 5'd0, 1, 0, 0, 0);
    n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL basic_first_ready: got %b want 1", bus.req_ready); else n_pass++;
    n_checks++; if ({rs1_read, rs2_read, rs1_addr, rs2_addr} !== {2'b11, 5'd3, 5'd0})
      $display("FAIL basic_read_port: got %b/%0d/%0d want 11/3/0", {rs1_read, rs2_read}, rs1_addr, rs2_addr); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL basic_no_early_rsp: got %b want 0", bus.rsp_valid); else n_pass++;
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL basic_rsp_valid: got %b want 1", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_rs1_data !== 32'h1234) $display("FAIL basic_rs1: got %h want 00001234", bus.rsp_rs1_data); else n_pass++;
    n_checks++; if (bus.rsp_rs2_data !== 32'h0) $display("FAIL basic_rs2_x0: got %h want 0", bus.rsp_rs2_data); else n_pass++;
    $display("txn basic rs1=%h rs2=%h", bus.rsp_rs1_data, bus.rsp_rs2_data);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL basic_idle: got %b want 0", bus.rsp_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      if (k <= 3) step(0, 1, 5'(k), 5'(k + 3), 1, 0, 0, 0);
      else        step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
      n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", k, bus.req_ready); else n_pass++;
      if (k >= 2) begin
        n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL b2b_valid_%0d: got %b want 1", k, bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_rs1_data !== init_val(k - 1))
          $display("FAIL b2b_rs1_%0d: got %h want %h", k, bus.rsp_rs1_data, init_val(k - 1)); else n_pass++;
        n_checks++; if (bus.rsp_rs2_data !== init_val(k + 2))
          $display("FAIL b2b_rs2_%0d: got %h want %h", k, bus.rsp_rs2_data, init_val(k + 2)); else n_pass++;
        $display("txn b2b rs1=%h rs2=%h", bus.rsp_rs1_data, bus.rsp_rs2_data);
      end
    end
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
  endtask

  task automatic test_bypass();
    logic [31:0] exp_v;
    exp_v = BYPASS ? 32'h0000_CAFE : init_val(5);
    step(0, 1, 5'd5, 5'd5, 1, 1, 5'd5, 32'h0000_CAFE);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
    n_checks++; if (bus.rsp_rs1_data !== exp_v) $display("FAIL bypass_rs1: got %h want %h", bus.rsp_rs1_data, exp_v); else n_pass++;
    n_checks++; if (bus.rsp_rs2_data !== exp_v) $display("FAIL bypass_rs2: got %h want %h", bus.rsp_rs2_data, exp_v); else n_pass++;
    $display("txn bypass rs1=%h rs2=%h", bus.rsp_rs1_data, bus.rsp_rs2_data);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
  endtask

  task automatic test_hold_snoop();
    logic [31:0] exp2;
    step(0, 1, 5'd4, 5'd7, 1, 0, 0, 0);
    step(0, 1, 5'd9, 5'd10, 0, 0, 0, 0);
    n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL hold_ready_data: got %b want 0", bus.req_ready); else n_pass++;
    n_checks++; if (rs1_read !== 1'b0) $display("FAIL hold_no_read: got %b want 0", rs1_read); else n_pass++;
    n_checks++; if (bus.rsp_rs2_data !== init_val(7)) $display("FAIL hold_rs2_data: got %h want %h", bus.rsp_rs2_data, init_val(7)); else n_pass++;
    step(0, 1, 5'd9, 5'd10, 0, 1, 5'd7, 32'h0000_BEEF);
    n_checks++; if (bus.rsp_rs2_data !== init_val(7)) $display("FAIL hold_rs2_same_cycle: got %h want %h", bus.rsp_rs2_data, init_val(7)); else n_pass++;
    exp2 = BYPASS ? 32'h0000_BEEF : init_val(7);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 5'd9, 5'd10, 0, 0, 0, 0);
      n_checks++; if (bus.rsp_rs2_data !== exp2) $display("FAIL hold_rs2_snoop_%0d: got %h want %h", k, bus.rsp_rs2_data, exp2); else n_pass++;
      n_checks++; if (bus.rsp_rs1_data !== init_val(4)) $display("FAIL hold_rs1_%0d: got %h want %h", k, bus.rsp_rs1_data, init_val(4)); else n_pass++;
      n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL hold_ready_%0d: got %b want 0", k, bus.req_ready); else n_pass++;
    end
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
    n_checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b11) $display("FAIL hold_consume: got %b want 11", {bus.rsp_valid, bus.req_ready}); else n_pass++;
    n_checks++; if (bus.rsp_rs2_data !== exp2) $display("FAIL hold_rs2_final: got %h want %h", bus.rsp_rs2_data, exp2); else n_pass++;
    $display("txn hold rs1=%h rs2=%h", bus.rsp_rs1_data, bus.rsp_rs2_data);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
    n_checks++; if (bus.rsp_rs2_data !== 32'h0) $display("FAIL idle_data_zero: got %h want 0", bus.rsp_rs2_data); else n_pass++;
  endtask

  task automatic test_x0_write();
    step(0, 1, 5'd0, 5'd2, 1, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 0, 1, 5'd0, 32'h0000_FFFF);
    step(0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    n_checks++; if (bus.rsp_rs1_data !== 32'h0) $display("FAIL x0_rs1: got %h want 0", bus.rsp_rs1_data); else n_pass++;
    n_checks++; if (bus.rsp_rs2_data !== init_val(2)) $display("FAIL x0_rs2: got %h want %h", bus.rsp_rs2_data, init_val(2)); else n_pass++;
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
    $display("txn x0 rs1=%h rs2=%h", bus.rsp_rs1_data, bus.rsp_rs2_data);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
  endtask

  task automatic test_reset_in_hold();
    step(0, 1, 5'd3, 5'd4, 1, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL rsthold_pre: got %b want 1", bus.rsp_valid); else n_pass++;
    step(1, 1, 5'd3, 5'd8, 1, 0, 0, 0);
    n_checks++; if ({bus.rsp_valid, bus.req_ready, rs1_read} !== 3'b000)
      $display("FAIL rsthold_in_reset: got %b want 000", {bus.rsp_valid, bus.req_ready, rs1_read}); else n_pass++;
    step(0, 1, 5'd3, 5'd8, 1, 0, 0, 0);
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rsthold_discard: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_rs1_data !== 32'h0) $display("FAIL rsthold_data: got %h want 0", bus.rsp_rs1_data); else n_pass++;
    n_checks++; if (rs1_read !== 1'b1) $display("FAIL rsthold_accept: got %b want 1", rs1_read); else n_pass++;
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
    n_checks++; if ({bus.rsp_valid, bus.rsp_rs1_data, bus.rsp_rs2_data} !== {1'b1, 32'h1234, init_val(8)})
      $display("FAIL rsthold_after: got %b %h %h want 1 00001234 %h", bus.rsp_valid, bus.rsp_rs1_data, bus.rsp_rs2_data, init_val(8)); else n_pass++;
    $display("txn post-reset rs1=%h rs2=%h", bus.rsp_rs1_data, bus.rsp_rs2_data);
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
  endtask

  task automatic test_random();
    logic        pend;
    logic [4:0]  pa1, pa2;
    logic [31:0] snap1, snap2, exp1, exp2;
    logic        exp_ready, acc, hs;
    int          txn;
    pend = 1'b0; pa1 = '0; pa2 = '0; snap1 = '0; snap2 = '0; txn = 0;
    step(1, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    for (int c = 0; c < 300; c++) begin
      step(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      exp_ready = !pend || bus.rsp_ready;
      exp1 = !pend ? 32'h0 : (pa1 == 5'd0) ? 32'h0 : (BYPASS ? mem[pa1] : snap1);
      exp2 = !pend ? 32'h0 : (pa2 == 5'd0) ? 32'h0 : (BYPASS ? mem[pa2] : snap2);
      n_checks++; if (bus.rsp_valid !== pend) $display("FAIL rnd_valid_%0d: got %b want %b", c, bus.rsp_valid, pend); else n_pass++;
      n_checks++; if (bus.req_ready !== exp_ready) $display("FAIL rnd_ready_%0d: got %b want %b", c, bus.req_ready, exp_ready); else n_pass++;
      n_checks++; if (bus.rsp_rs1_data !== exp1) $display("FAIL rnd_rs1_%0d: got %h want %h", c, bus.rsp_rs1_data, exp1); else n_pass++;
      n_checks++; if (bus.rsp_rs2_data !== exp2) $display("FAIL rnd_rs2_%0d: got %h want %h", c, bus.rsp_rs2_data, exp2); else n_pass++;
      acc = bus.req_valid && exp_ready;
      n_checks++; if (rs1_read !== acc || rs2_read !== acc) $display("FAIL rnd_read_en_%0d: got %b%b want %b", c, rs1_read, rs2_read, acc); else n_pass++;
      hs = pend && bus.rsp_ready;
      if (hs) begin
        txn++;
        $display("txn rnd %0d rs1[%0d]=%h rs2[%0d]=%h", txn, pa1, bus.rsp_rs1_data, pa2, bus.rsp_rs2_data);
      end
      if (acc) begin
        pend  = 1'b1;
        pa1   = bus.req_rs1_addr;
        pa2   = bus.req_rs2_addr;
        snap1 = mem[bus.req_rs1_addr];
        snap2 = mem[bus.req_rs2_addr];
      end else if (hs) begin
        pend = 1'b0;
      end
    end
    step(0, 0, 5'd0, 5'd0, 1, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000ns");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_bypass();
    test_hold_snoop();
    test_x0_write();
    test_reset_in_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
